// File: rtl/rf_pkg.sv
// ============================================================================
//  Module   : rf_pkg
//  Brief    : Shared types, constants and helpers for the register file slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_NREGS   = 32;
    localparam int RF_AW      = $clog2(RF_NREGS);
    localparam int RF_TAG_W   = 3;
    localparam int ZERO_REG   = 0;
    // Widest busy vector the population counter accepts.
    localparam int RF_POP_MAX = 256;

    typedef logic [RF_AW-1:0]    rf_idx_t;
    typedef logic [RF_TAG_W-1:0] rf_tag_t;

    function automatic int unsigned rf_popcount(input logic [RF_POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < RF_POP_MAX; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
//  Module   : rf_scoreboard
//  Brief    : Per-register busy/tag tracking with claim, tagged clear and flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS  = RF_NREGS,
    parameter  int NWR    = 2,
    parameter  int TAG_W  = RF_TAG_W,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWR-1:0]         i_wr_en,
    input  logic [NWR*AW-1:0]      i_wr_addr,
    input  logic [NWR*TAG_W-1:0]   i_wr_tag,
    input  logic                   i_claim_en,
    input  logic [AW-1:0]          i_claim_addr,
    input  logic [TAG_W-1:0]       i_claim_tag,
    input  logic                   i_flush,
    output logic [NREGS-1:0]       o_busy_vis,
    output logic [NREGS*TAG_W-1:0] o_tag_flat,
    output logic [AW:0]            o_busy_count
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [TAG_W-1:0] tag_q [NREGS];
    logic [TAG_W-1:0] tag_d [NREGS];
    logic [NREGS-1:0] clr_hit, claim_hit;
    logic [AW:0]      busy_count_q, busy_count_d;

    // Priority per register: hold < flush / tag-matching write < claim.
    always_comb begin
        busy_d    = busy_q;
        clr_hit   = '0;
        claim_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            tag_d[r] = tag_q[r];
        end
        for (int r = 1; r < NREGS; r++) begin
            claim_hit[r] = i_claim_en && (i_claim_addr == AW'(r));
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == AW'(r)) && busy_q[r] &&
                    (i_wr_tag[w*TAG_W +: TAG_W] == tag_q[r])) begin
                    clr_hit[r] = 1'b1;
                end
            end
            if (i_flush || clr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            if (claim_hit[r]) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = i_claim_tag;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
        tag_d[ZERO_REG]  = '0;
        busy_count_d     = (AW+1)'(rf_popcount(RF_POP_MAX'(busy_d)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_count_q <= '0;
        end else begin
            busy_count_q <= busy_count_d;
        end
    end

    // With bypass, a retiring producer is hidden unless a new claim lands too.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            o_busy_vis[r] = (BYPASS != 0) ? (busy_q[r] & ~(clr_hit[r] & ~claim_hit[r]))
                                          : busy_q[r];
            o_tag_flat[r*TAG_W +: TAG_W] = tag_q[r];
        end
    end

    assign o_busy_count = busy_count_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : Multi-port register file with write bypass and RAW scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = 64,
    parameter  int NREGS  = RF_NREGS,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int TAG_W  = RF_TAG_W,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic [NWR*TAG_W-1:0]  wr_tag,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_addr,
    input  logic [TAG_W-1:0]      claim_tag,
    input  logic                  flush,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0]        mem_q [1:NREGS-1];
    logic [XLEN-1:0]        mem_d [1:NREGS-1];
    logic [NREGS-1:0]       busy_vis;
    logic [NREGS*TAG_W-1:0] tag_flat;
    logic                   use_bypass;

    // Ascending port order lets the highest-numbered port win on collisions.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
                    mem_d[r] = wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NWR    (NWR),
        .TAG_W  (TAG_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_tag     (wr_tag),
        .i_claim_en   (claim_en),
        .i_claim_addr (claim_addr),
        .i_claim_tag  (claim_tag),
        .i_flush      (flush),
        .o_busy_vis   (busy_vis),
        .o_tag_flat   (tag_flat),
        .o_busy_count (busy_count)
    );

    // In-flight write data must not leak out while reset holds the array clear.
    assign use_bypass = (BYPASS != 0) && reset;

    // Index 0 and out-of-range indices match no entry and read as zero.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN]  = '0;
            rd_busy[p]               = 1'b0;
            rd_tag[p*TAG_W +: TAG_W] = '0;
            for (int r = 1; r < NREGS; r++) begin
                if (rd_addr[p*AW +: AW] == AW'(r)) begin
                    rd_data[p*XLEN +: XLEN]  = use_bypass ? mem_d[r] : mem_q[r];
                    rd_busy[p]               = busy_vis[r];
                    rd_tag[p*TAG_W +: TAG_W] = tag_flat[r*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
//  Module   : tb_reg_file_sb
//  Brief    : Self-checking bench for reg_file_sb, bypass and registered views.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;
    import rf_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int TAG_W = 3;
    localparam int AW    = 5;
    localparam int NVEC  = 22;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic [NWR*TAG_W-1:0] wr_tag;
    logic                 claim_en;
    logic [AW-1:0]        claim_addr;
    logic [TAG_W-1:0]     claim_tag;
    logic                 flush;

    logic [NRD*XLEN-1:0]  rd_data_b1, rd_data_b0;
    logic [NRD-1:0]       rd_busy_b1, rd_busy_b0;
    logic [NRD*TAG_W-1:0] rd_tag_b1, rd_tag_b0;
    logic [AW:0]          busy_count_b1, busy_count_b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                  .TAG_W(TAG_W), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b1),
        .rd_busy(rd_busy_b1), .rd_tag(rd_tag_b1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_tag(wr_tag), .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_tag(claim_tag), .flush(flush), .busy_count(busy_count_b1)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                  .TAG_W(TAG_W), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b0),
        .rd_busy(rd_busy_b0), .rd_tag(rd_tag_b0), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_tag(wr_tag), .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_tag(claim_tag), .flush(flush), .busy_count(busy_count_b0)
    );

    typedef struct {
        logic [1:0]  we;
        rf_idx_t     wa0;  logic [63:0] wd0;  rf_tag_t wt0;
        rf_idx_t     wa1;  logic [63:0] wd1;  rf_tag_t wt1;
        logic        ce;   rf_idx_t     ca;   rf_tag_t ct;
        logic        fl;
        rf_idx_t     ra0;  rf_idx_t     ra1;
        logic [63:0] e_d0_b1, e_d0_b0;
        logic        e_bz_b1, e_bz_b0;
        rf_tag_t     e_tg;
        logic [63:0] e_d1;
        logic [5:0]  e_cnt;
    } vec_t;

    typedef struct {
        int          row;
        logic [63:0] d0_b1, d0_b0;
        logic        bz_b1, bz_b0;
        rf_tag_t     tg;
        logic [63:0] d1;
        logic [5:0]  cnt;
    } exp_t;

    vec_t vt [NVEC];
    exp_t sb_q [$];

    function automatic vec_t mk(
        input logic [1:0] we,
        input rf_idx_t wa0, input logic [63:0] wd0, input rf_tag_t wt0,
        input rf_idx_t wa1, input logic [63:0] wd1, input rf_tag_t wt1,
        input logic ce, input rf_idx_t ca, input rf_tag_t ct, input logic fl,
        input rf_idx_t ra0, input rf_idx_t ra1,
        input logic [63:0] d0b1, input logic [63:0] d0b0,
        input logic bzb1, input logic bzb0, input rf_tag_t tg,
        input logic [63:0] d1, input logic [5:0] cnt);
        vec_t v;
        v.we = we;  v.wa0 = wa0; v.wd0 = wd0; v.wt0 = wt0;
        v.wa1 = wa1; v.wd1 = wd1; v.wt1 = wt1;
        v.ce = ce;  v.ca = ca;   v.ct = ct;   v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e_d0_b1 = d0b1; v.e_d0_b0 = d0b0;
        v.e_bz_b1 = bzb1; v.e_bz_b0 = bzb0;
        v.e_tg = tg; v.e_d1 = d1; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_tag = '0;
        claim_en = 1'b0; claim_addr = '0; claim_tag = '0; flush = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_data_b1"}, -1, rd_data_b1[63:0], 64'h0);
        chk({nm, "_data1_b1"}, -1, rd_data_b1[127:64], 64'h0);
        chk({nm, "_data_b0"}, -1, rd_data_b0[63:0], 64'h0);
        chk({nm, "_data1_b0"}, -1, rd_data_b0[127:64], 64'h0);
        chk({nm, "_busy"}, -1, 64'(rd_busy_b1), 64'h0);
        chk({nm, "_cnt"}, -1, 64'(busy_count_b1), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        //              we    wa0 wd0          wt0 wa1 wd1      wt1 ce ca ct fl ra0 ra1  d0_b1         d0_b0    bz1 bz0 tg d1       cnt
        vt[0]  = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 5, 64'h0,        64'h0,    0, 0, 0, 64'h0,    0);
        vt[1]  = mk(2'b11, 5, 64'hDEADBEEF, 0, 5, 64'h1234, 0, 0, 0, 0, 0, 5, 5, 64'h1234,     64'h0,    0, 0, 0, 64'h1234, 0);
        vt[2]  = mk(2'b01, 0, 64'hFF,       0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 5, 64'h0,        64'h0,    0, 0, 0, 64'h1234, 0);
        vt[3]  = mk(2'b01, 7, 64'h55,       0, 0, 64'h0,    0, 0, 0, 0, 0, 7, 0, 64'h55,       64'h0,    0, 0, 0, 64'h0,    0);
        vt[4]  = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 7, 5, 64'h55,       64'h55,   0, 0, 0, 64'h1234, 0);
        vt[5]  = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 1, 3, 2, 0, 3, 0, 64'h0,        64'h0,    0, 0, 0, 64'h0,    0);
        vt[6]  = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 1, 3, 4, 0, 3, 0, 64'h0,        64'h0,    1, 1, 2, 64'h0,    1);
        vt[7]  = mk(2'b01, 3, 64'h33,       2, 0, 64'h0,    0, 0, 0, 0, 0, 3, 0, 64'h33,       64'h0,    1, 1, 4, 64'h0,    1);
        vt[8]  = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 3, 0, 64'h33,       64'h33,   1, 1, 4, 64'h0,    1);
        vt[9]  = mk(2'b01, 3, 64'h44,       4, 0, 64'h0,    0, 0, 0, 0, 0, 3, 0, 64'h44,       64'h33,   0, 1, 4, 64'h0,    1);
        vt[10] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 3, 0, 64'h44,       64'h44,   0, 0, 4, 64'h0,    0);
        vt[11] = mk(2'b01, 1, 64'h11,       7, 0, 64'h0,    0, 1, 1, 1, 0, 1, 0, 64'h11,       64'h0,    0, 0, 0, 64'h0,    0);
        vt[12] = mk(2'b01, 2, 64'h22,       0, 0, 64'h0,    0, 1, 2, 2, 0, 1, 2, 64'h11,       64'h11,   1, 1, 1, 64'h22,   1);
        vt[13] = mk(2'b01, 9, 64'h99,       0, 0, 64'h0,    0, 1, 9, 3, 0, 2, 9, 64'h22,       64'h22,   1, 1, 2, 64'h99,   2);
        vt[14] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 9, 1, 64'h99,       64'h99,   1, 1, 3, 64'h11,   3);
        vt[15] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 1, 4, 5, 1, 4, 2, 64'h0,        64'h0,    0, 0, 0, 64'h22,   3);
        vt[16] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 1, 9, 64'h11,       64'h11,   0, 0, 1, 64'h99,   1);
        vt[17] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 4, 2, 64'h0,        64'h0,    1, 1, 5, 64'h22,   1);
        vt[18] = mk(2'b01, 4, 64'h4444,     5, 0, 64'h0,    0, 1, 4, 6, 0, 4, 0, 64'h4444,     64'h0,    1, 1, 5, 64'h0,    1);
        vt[19] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 4, 0, 64'h4444,     64'h4444, 1, 1, 6, 64'h0,    1);
        vt[20] = mk(2'b11, 4, 64'hA,        6, 4, 64'hB,    1, 0, 0, 0, 0, 4, 0, 64'hB,        64'h4444, 0, 1, 6, 64'h0,    1);
        vt[21] = mk(2'b00, 0, 64'h0,        0, 0, 64'h0,    0, 0, 0, 0, 0, 4, 0, 64'hB,        64'hB,    0, 0, 6, 64'h0,    0);

        // Reset held from time zero: everything reads cleared.
        reset = 1'b0;
        idle_inputs();
        rd_addr = {5'd5, 5'd0};
        #2;
        check_all_zero("in_reset");
        #10 reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            wr_en      = vt[i].we;
            wr_addr    = {vt[i].wa1, vt[i].wa0};
            wr_data    = {vt[i].wd1, vt[i].wd0};
            wr_tag     = {vt[i].wt1, vt[i].wt0};
            claim_en   = vt[i].ce;
            claim_addr = vt[i].ca;
            claim_tag  = vt[i].ct;
            flush      = vt[i].fl;
            rd_addr    = {vt[i].ra1, vt[i].ra0};
            e.row   = i;
            e.d0_b1 = vt[i].e_d0_b1;  e.d0_b0 = vt[i].e_d0_b0;
            e.bz_b1 = vt[i].e_bz_b1;  e.bz_b0 = vt[i].e_bz_b0;
            e.tg    = vt[i].e_tg;     e.d1    = vt[i].e_d1;
            e.cnt   = vt[i].e_cnt;
            sb_q.push_back(e);

            @(negedge clk);
            e = sb_q.pop_front();
            chk("rd_data0_b1", e.row, rd_data_b1[63:0], e.d0_b1);
            chk("rd_data0_b0", e.row, rd_data_b0[63:0], e.d0_b0);
            chk("rd_busy0_b1", e.row, 64'(rd_busy_b1[0]), 64'(e.bz_b1));
            chk("rd_busy0_b0", e.row, 64'(rd_busy_b0[0]), 64'(e.bz_b0));
            chk("rd_tag0_b1", e.row, 64'(rd_tag_b1[2:0]), 64'(e.tg));
            chk("rd_tag0_b0", e.row, 64'(rd_tag_b0[2:0]), 64'(e.tg));
            chk("rd_data1_b1", e.row, rd_data_b1[127:64], e.d1);
            chk("busy_count_b1", e.row, 64'(busy_count_b1), 64'(e.cnt));
            chk("busy_count_b0", e.row, 64'(busy_count_b0), 64'(e.cnt));
        end
        chk("scoreboard_drained", -1, 64'(sb_q.size()), 64'h0);

        // Reset dropped mid-cycle while a claim and writes are active.
        @(posedge clk);
        #1;
        wr_en = 2'b11; wr_addr = {5'd7, 5'd5}; wr_data = {64'h88, 64'h77}; wr_tag = '0;
        claim_en = 1'b1; claim_addr = 5'd5; claim_tag = 3'd1;
        rd_addr = {5'd7, 5'd5};
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_edge");
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check_all_zero("after_reset");
        chk("after_reset_tag", -1, 64'(rd_tag_b1[2:0]), 64'h0);
        @(posedge clk);
        #1;
        chk("after_reset_cnt", -1, 64'(busy_count_b1), 64'h0);
        chk("after_reset_r4", -1, 64'(rd_busy_b0), 64'h0);
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("after_reset_r3", -1, rd_data_b0[63:0], 64'h0);
        chk("after_reset_r4d", -1, rd_data_b0[127:64], 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
